// File: rtl/timer_setter_pkg.sv
//============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the timer_setter control stage.
//               Holds the BCD digit width, the `set` mode codes driven to
//               the MM:SS down-counter, the 3-bit state encodings with the
//               matching enum, and a helper that maps a state to its `set`
//               code.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package timer_pkg;

   localparam int BCD_W = 4;

   // Mode codes presented to the counter; it loads in3..in0 whenever the
   // code is not SET_HOLD.
   localparam logic [1:0] SET_HOLD = 2'b00;
   localparam logic [1:0] SET_MIN  = 2'b01;
   localparam logic [1:0] SET_SEC  = 2'b10;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SET_MIN = 3'd1;
   localparam logic [2:0] ST_SET_SEC = 3'd2;
   localparam logic [2:0] ST_LOAD    = 3'd3;
   localparam logic [2:0] ST_RUN     = 3'd4;
   localparam logic [2:0] ST_PAUSE   = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_SET_MIN = ST_SET_MIN,
      S_SET_SEC = ST_SET_SEC,
      S_LOAD    = ST_LOAD,
      S_RUN     = ST_RUN,
      S_PAUSE   = ST_PAUSE,
      S_DONE    = ST_DONE
   } state_t;

   // LOAD reuses the minutes code so the counter takes the full preset in
   // one edge before counting starts.
   function automatic logic [1:0] set_code(input state_t s);
      logic [1:0] code;
      code = SET_HOLD;
      case (s)
         S_SET_MIN, S_LOAD: code = SET_MIN;
         S_SET_SEC:         code = SET_SEC;
         default:           code = SET_HOLD;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timer_setter_if.sv
//============================================================================
// Module      : timer_setter_if
// Description : Bundles the button pulses and counter zero flag (into the
//               setter) with the preset digits, mode code, run enable and
//               alarm (out of the setter).
// Modports    : master - the timer_setter side
//               slave  - the environment / counter side
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface timer_setter_if;
   import timer_pkg::*;

   logic             btn_mode;
   logic             btn_inc;
   logic             btn_dec;
   logic             btn_run;
   logic             cnt_zero;
   logic [1:0]       set;
   logic             switch;
   logic [BCD_W-1:0] in0;
   logic [BCD_W-1:0] in1;
   logic [BCD_W-1:0] in2;
   logic [BCD_W-1:0] in3;
   logic             alarm;

   modport master (
      input  btn_mode, btn_inc, btn_dec, btn_run, cnt_zero,
      output set, switch, in0, in1, in2, in3, alarm
   );

   modport slave (
      output btn_mode, btn_inc, btn_dec, btn_run, cnt_zero,
      input  set, switch, in0, in1, in2, in3, alarm
   );

endinterface

`default_nettype wire

// File: rtl/timer_setter_bcd2_updown.sv
//============================================================================
// Module      : bcd2_updown
// Description : Two-digit BCD up/down counter wrapping between 00 and MAX.
//               Ones carry/borrow into tens. Simultaneous inc and dec leave
//               the value unchanged.
// Ports       : clk, rst_n (sync active-low), en_inc, en_dec,
//               tens, ones (BCD outputs, registered)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module bcd2_updown
   import timer_pkg::*;
#(
   parameter int MAX = 99
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_inc,
   input  logic             en_dec,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   localparam logic [BCD_W-1:0] C_MAX_TENS = BCD_W'(MAX / 10);
   localparam logic [BCD_W-1:0] C_MAX_ONES = BCD_W'(MAX % 10);
   localparam logic [BCD_W-1:0] C_NINE     = BCD_W'(9);
   localparam logic [BCD_W-1:0] C_ONE      = BCD_W'(1);
   localparam logic [BCD_W-1:0] C_ZERO     = '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tens <= C_ZERO;
         ones <= C_ZERO;
      end else if (en_inc && !en_dec) begin
         if (tens == C_MAX_TENS && ones == C_MAX_ONES) begin
            tens <= C_ZERO;
            ones <= C_ZERO;
         end else if (ones == C_NINE) begin
            tens <= tens + C_ONE;
            ones <= C_ZERO;
         end else begin
            ones <= ones + C_ONE;
         end
      end else if (en_dec && !en_inc) begin
         if (tens == C_ZERO && ones == C_ZERO) begin
            tens <= C_MAX_TENS;
            ones <= C_MAX_ONES;
         end else if (ones == C_ZERO) begin
            tens <= tens - C_ONE;
            ones <= C_NINE;
         end else begin
            ones <= ones - C_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/timer_setter.sv
//============================================================================
// Module      : timer_setter
// Description : Control stage ahead of the MM:SS down-counter. Converts
//               one-cycle button pulses into BCD preset digits, the `set`
//               mode code and the `switch` run enable, and sequences
//               run / pause / done / alarm from the counter zero flag.
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset
//               bus      - timer_setter_if.master (buttons, cnt_zero in;
//                          set, switch, in3..in0, alarm out)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module timer_setter
   import timer_pkg::*;
#(
   parameter int MAX_MIN      = 99,
   parameter int MAX_SEC      = 59,
   parameter int ALARM_CYCLES = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   timer_setter_if.master  bus
);

   localparam int C_ACNT_W = $clog2(ALARM_CYCLES + 1);
   localparam logic [C_ACNT_W-1:0] C_ACNT_LOAD = C_ACNT_W'(ALARM_CYCLES - 1);
   localparam logic [C_ACNT_W-1:0] C_ACNT_ONE  = C_ACNT_W'(1);

   state_t              r_state;
   state_t              w_state_nx;
   logic [C_ACNT_W-1:0] r_alarm_cnt;
   logic                w_any_btn;
   logic                w_digits_zero;
   logic                w_min_inc;
   logic                w_min_dec;
   logic                w_sec_inc;
   logic                w_sec_dec;

   always_comb begin
      w_any_btn     = bus.btn_mode | bus.btn_inc | bus.btn_dec | bus.btn_run;
      w_digits_zero = ({bus.in3, bus.in2, bus.in1, bus.in0} == '0);

      // A mode press in the same cycle wins over editing.
      w_min_inc = (r_state == S_SET_MIN) && bus.btn_inc && !bus.btn_mode;
      w_min_dec = (r_state == S_SET_MIN) && bus.btn_dec && !bus.btn_mode;
      w_sec_inc = (r_state == S_SET_SEC) && bus.btn_inc && !bus.btn_mode;
      w_sec_dec = (r_state == S_SET_SEC) && bus.btn_dec && !bus.btn_mode;

      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.btn_mode) begin
               w_state_nx = S_SET_MIN;
            end else if (bus.btn_run) begin
               // Counter still holds a value: resume it directly. Counter
               // at zero: reload the preset first, unless that is zero too.
               if (!bus.cnt_zero) begin
                  w_state_nx = S_RUN;
               end else if (!w_digits_zero) begin
                  w_state_nx = S_LOAD;
               end
            end
         end
         S_SET_MIN: if (bus.btn_mode) w_state_nx = S_SET_SEC;
         S_SET_SEC: if (bus.btn_mode) w_state_nx = S_IDLE;
         S_LOAD:    w_state_nx = S_RUN;
         S_RUN: begin
            if (bus.cnt_zero) begin
               w_state_nx = S_DONE;
            end else if (bus.btn_run) begin
               w_state_nx = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (bus.btn_mode) begin
               w_state_nx = S_SET_MIN;
            end else if (bus.btn_run) begin
               w_state_nx = S_RUN;
            end
         end
         S_DONE: begin
            if (w_any_btn || r_alarm_cnt == '0) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they always equal the
   // decode of the state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_alarm_cnt <= '0;
         bus.set     <= SET_HOLD;
         bus.switch  <= 1'b0;
         bus.alarm   <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         bus.set    <= set_code(w_state_nx);
         bus.switch <= (w_state_nx == S_RUN);
         bus.alarm  <= (w_state_nx == S_DONE);

         if (r_state != S_DONE && w_state_nx == S_DONE) begin
            r_alarm_cnt <= C_ACNT_LOAD;
         end else if (w_state_nx == S_DONE) begin
            r_alarm_cnt <= r_alarm_cnt - C_ACNT_ONE;
         end else begin
            r_alarm_cnt <= '0;
         end
      end
   end

   bcd2_updown #(.MAX(MAX_MIN)) u_minutes (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_inc (w_min_inc),
      .en_dec (w_min_dec),
      .tens   (bus.in3),
      .ones   (bus.in2)
   );

   bcd2_updown #(.MAX(MAX_SEC)) u_seconds (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_inc (w_sec_inc),
      .en_dec (w_sec_dec),
      .tens   (bus.in1),
      .ones   (bus.in0)
   );

endmodule

`default_nettype wire
